// File: rtl/pulse_irq_coalesce.sv
// pulse_irq_coalesce
//
// Interrupt moderation stage. Event pulses (at most one per cycle) are counted
// into a batch. One interrupt request is raised per batch, either when the
// count reaches the threshold or when the timeout since the first event of the
// batch expires. The request is held on a valid/ready handshake towards the
// MSI/MSI-X generator together with the vector index and the batch size.
//
// Handshake: irq_valid, once high, stays high with irq_index and irq_count
// stable until the cycle where irq_ready is also high. That cycle is the
// transfer. irq_valid is low in the next cycle. At least one cycle with
// irq_valid low separates two requests.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pulse_in          one event per high cycle
//   cfg_enable        1 = requests may be issued, 0 = count only
//   cfg_count_thr     batch threshold (0 or 1 fires on the first event)
//   cfg_timeout       cycles from the first event of a batch to a forced fire
//   cfg_irq_index     vector index reported with the request
//   cfg_holdoff       (PULSE_IRQ_HOLDOFF_EN only) fire inhibit after a transfer
//   irq_valid/ready   request handshake
//   irq_index         vector index, stable while irq_valid
//   irq_count         events in the issued batch, stable while irq_valid
//   pending_count     events accumulated and not yet issued
//   dbg_state         current FSM state
//
// Build option: define PULSE_IRQ_HOLDOFF_EN to add the HOLDOFF state and the
// cfg_holdoff input.

module pulse_irq_coalesce #(
    parameter int COUNT_WIDTH     = 16,
    parameter int TIMER_WIDTH     = 16,
    parameter int IRQ_INDEX_WIDTH = 5
`ifdef PULSE_IRQ_HOLDOFF_EN
    ,
    parameter int HOLDOFF_WIDTH   = 16
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pulse_in,
    input  logic                       cfg_enable,
    input  logic [COUNT_WIDTH-1:0]     cfg_count_thr,
    input  logic [TIMER_WIDTH-1:0]     cfg_timeout,
    input  logic [IRQ_INDEX_WIDTH-1:0] cfg_irq_index,
`ifdef PULSE_IRQ_HOLDOFF_EN
    input  logic [HOLDOFF_WIDTH-1:0]   cfg_holdoff,
`endif
    output logic                       irq_valid,
    input  logic                       irq_ready,
    output logic [IRQ_INDEX_WIDTH-1:0] irq_index,
    output logic [COUNT_WIDTH-1:0]     irq_count,
    output logic [COUNT_WIDTH-1:0]     pending_count,
    output logic [1:0]                 dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
`ifdef PULSE_IRQ_HOLDOFF_EN
    localparam logic [1:0] S_HOLDOFF = 2'd3;
`endif

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [1:0]                 state_q, state_d;
    logic [COUNT_WIDTH-1:0]     count_q, count_d;
    logic [TIMER_WIDTH-1:0]     timer_q, timer_d;
    logic                       irq_valid_q, irq_valid_d;
    logic [IRQ_INDEX_WIDTH-1:0] irq_index_q, irq_index_d;
    logic [COUNT_WIDTH-1:0]     irq_count_q, irq_count_d;
`ifdef PULSE_IRQ_HOLDOFF_EN
    logic [HOLDOFF_WIDTH-1:0]   holdoff_q, holdoff_d;
`endif

    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   fire;
    logic                   handshake;

    always_comb begin
        // Count including this cycle's pulse, saturating at all-ones.
        count_inc = count_q;
        if (pulse_in && (count_q != COUNT_MAX)) begin
            count_inc = count_q + 1'b1;
        end

        // timer_d is the remaining time as seen in this cycle: cfg_timeout in
        // the cycle of the first event, one less each later cycle. A zero here
        // fires this cycle, so timeout T gives irq_valid T+1 cycles after the
        // first event.
        timer_d = '0;
        if (pulse_in && (count_q == '0)) begin
            timer_d = cfg_timeout;
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end

        fire = cfg_enable && (count_inc != '0) &&
               ((count_inc >= cfg_count_thr) || (timer_d == '0));
        handshake = irq_valid_q && irq_ready;

        state_d     = state_q;
        count_d     = count_inc;
        irq_valid_d = irq_valid_q;
        irq_index_d = irq_index_q;
        irq_count_d = irq_count_q;
`ifdef PULSE_IRQ_HOLDOFF_EN
        holdoff_d   = holdoff_q;
`endif

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (fire) begin
                    irq_valid_d = 1'b1;
                    irq_index_d = cfg_irq_index;
                    irq_count_d = count_inc;
                    count_d     = '0;
                    state_d     = S_REQ;
                end else if (count_inc != '0) begin
                    state_d = S_ACCUM;
                end
            end
            S_REQ: begin
                // Pulses keep counting into the next batch while we wait.
                if (handshake) begin
                    irq_valid_d = 1'b0;
                    state_d     = (count_inc != '0) ? S_ACCUM : S_IDLE;
`ifdef PULSE_IRQ_HOLDOFF_EN
                    if (cfg_holdoff != '0) begin
                        holdoff_d = cfg_holdoff;
                        state_d   = S_HOLDOFF;
                    end
`endif
                end
            end
`ifdef PULSE_IRQ_HOLDOFF_EN
            S_HOLDOFF: begin
                // Occupies exactly cfg_holdoff cycles; no fire evaluation here.
                holdoff_d = holdoff_q - 1'b1;
                if (holdoff_q == {{(HOLDOFF_WIDTH-1){1'b0}}, 1'b1}) begin
                    state_d = (count_inc != '0) ? S_ACCUM : S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            timer_q     <= '0;
            irq_valid_q <= 1'b0;
            irq_index_q <= '0;
            irq_count_q <= '0;
`ifdef PULSE_IRQ_HOLDOFF_EN
            holdoff_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            irq_valid_q <= irq_valid_d;
            irq_index_q <= irq_index_d;
            irq_count_q <= irq_count_d;
`ifdef PULSE_IRQ_HOLDOFF_EN
            holdoff_q   <= holdoff_d;
`endif
        end
    end

    assign irq_valid     = irq_valid_q;
    assign irq_index     = irq_index_q;
    assign irq_count     = irq_count_q;
    assign pending_count = count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pulse_irq_coalesce.sv
// Bench for pulse_irq_coalesce. Small counter/timer widths make saturation
// reachable. A cycle-level reference model expressed in plain integers
// (pending events, absolute deadline cycle, earliest-fire cycle) predicts
// irq_valid and pending_count each cycle, and pushes each request's
// {index, count} into exp_q. A separate monitor compares what the DUT presents.

module tb_pulse_irq_coalesce;

  localparam int CW = 4;
  localparam int TW = 6;
  localparam int IW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pulse_in;
  logic          cfg_enable;
  logic [CW-1:0] cfg_count_thr;
  logic [TW-1:0] cfg_timeout;
  logic [IW-1:0] cfg_irq_index;
  logic          irq_valid;
  logic          irq_ready;
  logic [IW-1:0] irq_index;
  logic [CW-1:0] irq_count;
  logic [CW-1:0] pending_count;
  logic [1:0]    dbg_state;
`ifdef PULSE_IRQ_HOLDOFF_EN
  logic [15:0]   cfg_holdoff;
`endif

  pulse_irq_coalesce #(
    .COUNT_WIDTH(CW),
    .TIMER_WIDTH(TW),
    .IRQ_INDEX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pulse_in(pulse_in),
    .cfg_enable(cfg_enable),
    .cfg_count_thr(cfg_count_thr),
    .cfg_timeout(cfg_timeout),
    .cfg_irq_index(cfg_irq_index),
`ifdef PULSE_IRQ_HOLDOFF_EN
    .cfg_holdoff(cfg_holdoff),
`endif
    .irq_valid(irq_valid),
    .irq_ready(irq_ready),
    .irq_index(irq_index),
    .irq_count(irq_count),
    .pending_count(pending_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  bit running = 1'b0;

  logic [IW+CW-1:0] exp_q[$];

  // current-cycle expectations (valid after the most recent edge)
  bit exp_valid = 1'b0;
  int exp_pend = 0;

  // reference model state
  int cyc = 0;
  int m_pend = 0;
  int m_deadline = 0;
  bit m_req = 1'b0;
  int m_fire_ok_from = 0;

  // configuration applied by tick()
  bit g_en = 1'b1;
  int g_thr = 1;
  int g_tmo = 10;
  int g_idx = 0;
  bit g_rdy = 1'b1;
  int g_hold = 0;

  // ---------------- reference model ----------------
  task automatic model_next(input bit p, input bit rs);
    int pend_now;
    int hold_eff;
    logic [IW-1:0] li;
    logic [CW-1:0] lc;
    if (rs) begin
      m_pend = 0;
      m_req = 1'b0;
      m_deadline = 0;
      m_fire_ok_from = 0;
      exp_q.delete();
      return;
    end
`ifdef PULSE_IRQ_HOLDOFF_EN
    hold_eff = g_hold;
`else
    hold_eff = 0;
`endif
    pend_now = m_pend + (p ? 1 : 0);
    if (pend_now > CMAX) pend_now = CMAX;
    if (m_pend == 0 && p) m_deadline = cyc + g_tmo;
    if (!m_req && cyc >= m_fire_ok_from && g_en && pend_now > 0 &&
        (pend_now >= g_thr || cyc >= m_deadline)) begin
      li = IW'(g_idx);
      lc = CW'(pend_now);
      exp_q.push_back({li, lc});
      m_req = 1'b1;
      m_pend = 0;
    end else if (m_req && g_rdy) begin
      m_req = 1'b0;
      m_pend = pend_now;
      m_fire_ok_from = cyc + 1 + hold_eff;
    end else begin
      m_pend = pend_now;
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit p, input bit rs);
    pulse_in      = p;
    rst           = rs;
    cfg_enable    = g_en;
    cfg_count_thr = CW'(g_thr);
    cfg_timeout   = TW'(g_tmo);
    cfg_irq_index = IW'(g_idx);
    irq_ready     = g_rdy;
`ifdef PULSE_IRQ_HOLDOFF_EN
    cfg_holdoff   = 16'(g_hold);
`endif
    model_next(p, rs);
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = m_req;
    exp_pend  = m_pend;
  endtask

  task automatic tick(input bit p);
    step(p, 1'b0);
  endtask

  task automatic ticks(input bit p, input int n);
    for (int i = 0; i < n; i++) tick(p);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (running) begin
      checks++;
      if (irq_valid !== exp_valid) begin
        failures++;
        $display("FAIL irq_valid cyc=%0d got=%0b exp=%0b", cyc, irq_valid, exp_valid);
      end
      checks++;
      if (pending_count !== CW'(exp_pend)) begin
        failures++;
        $display("FAIL pending_count cyc=%0d got=%0d exp=%0d", cyc, pending_count, exp_pend);
      end
      if (!rst && irq_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL irq_unexpected cyc=%0d got index=%0d count=%0d exp=none",
                   cyc, irq_index, irq_count);
        end else if ({irq_index, irq_count} !== exp_q[0]) begin
          failures++;
          $display("FAIL irq_payload cyc=%0d got index=%0d count=%0d exp index=%0d count=%0d",
                   cyc, irq_index, irq_count, exp_q[0][IW+CW-1:CW], exp_q[0][CW-1:0]);
        end
        if (irq_ready === 1'b1 && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    pulse_in = 1'b0;
    rst = 1'b1;
    cfg_enable = 1'b0;
    cfg_count_thr = '0;
    cfg_timeout = '0;
    cfg_irq_index = '0;
    irq_ready = 1'b0;
`ifdef PULSE_IRQ_HOLDOFF_EN
    cfg_holdoff = '0;
`endif
    // reset
    step(1'b0, 1'b1);
    running = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if (irq_index !== '0 || irq_count !== '0) begin
      failures++;
      $display("FAIL reset_outputs got index=%0d count=%0d exp index=0 count=0", irq_index, irq_count);
    end

    // threshold 4, four back-to-back pulses
    g_en = 1; g_thr = 4; g_tmo = 40; g_idx = 3; g_rdy = 1; g_hold = 0;
    ticks(1'b1, 4);
    ticks(1'b0, 5);

    // timeout path: single pulse, timeout 10
    g_thr = 15; g_tmo = 10; g_idx = 9;
    tick(1'b1);
    ticks(1'b0, 14);

    // backpressure: request held stable while 5 pulses accumulate
    g_thr = 2; g_tmo = 60; g_idx = 7; g_rdy = 0;
    ticks(1'b1, 2);
    ticks(1'b1, 5);
    ticks(1'b0, 13);
    g_rdy = 1;
    ticks(1'b0, 6);

    // saturation with enable low, then re-enable
    g_en = 0; g_thr = 15; g_tmo = 5; g_idx = 21;
    ticks(1'b1, 20);
    g_en = 1;
    ticks(1'b0, 4);

    // reset while a request is outstanding
    g_thr = 1; g_rdy = 0; g_idx = 4;
    tick(1'b1);
    tick(1'b0);
    step(1'b0, 1'b1);
    ticks(1'b0, 5);
    g_rdy = 1;
    ticks(1'b0, 3);

`ifdef PULSE_IRQ_HOLDOFF_EN
    // holdoff spacing
    g_hold = 8; g_thr = 1; g_rdy = 1; g_idx = 12;
    ticks(1'b1, 40);
    g_hold = 0;
    ticks(1'b0, 12);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        g_thr  = int'($urandom_range(0, 15));
        g_tmo  = int'($urandom_range(0, 20));
        g_idx  = int'($urandom_range(0, 31));
        g_hold = int'($urandom_range(0, 4));
        g_en   = ($urandom_range(0, 9) != 0);
      end
      g_rdy = ($urandom_range(0, 9) < 7);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
    end

    // drain
    g_en = 1; g_rdy = 1; g_thr = 1; g_hold = 0;
    ticks(1'b0, 100);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending_requests=%0d exp=0", exp_q.size());
    end

    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
